vend_engine: RTL and testbench
==============================

Name: vend_engine

Overview:
Transaction engine directly downstream of the APB configuration block. It consumes the item table that configuration writes into the shared item memory. It accumulates customer credit, looks up the selected item (price/stock), validates the purchase, decrements stock in memory, and issues dispense and change pulses. It is idle-gated by cfg_mode so that no purchase starts while the table is being reprogrammed.

Parameters:
MAX_ITEMS, 1024, item memory depth; address width AW = $clog2(MAX_ITEMS) (localparam)
NUM_ITEMS, 1024, number of populated slots; item_sel >= NUM_ITEMS is invalid (NUM_ITEMS <= MAX_ITEMS)
CREDIT_W, 16, credit/price/change width

Ports:
pclk  in  1  clock
prst  in  1  synchronous active-high reset
cfg_mode  in  1  configuration active, already synchronous to pclk; blocks new transactions
coin_valid  in  1  one-cycle coin strobe
coin_value  in  CREDIT_W  coin value in cents, sampled when coin_valid=1
cancel  in  1  refund request strobe
item_sel_valid  in  1  one-cycle selection strobe
item_sel  in  AW  selected slot
mem_raddr  out  AW  item memory read address
mem_rdata  in  32  entry: [15:0] price, [23:16] stock, [31:24] flags (preserved)
mem_we  out  1  stock write-back strobe
mem_waddr  out  AW  write address
mem_wdata  out  32  updated entry
credit  out  CREDIT_W  current credit
busy  out  1  high in any state other than IDLE
dispense_valid  out  1  one-cycle dispense pulse
dispense_item  out  AW  slot dispensed, valid with dispense_valid
change_valid  out  1  one-cycle change pulse
change_value  out  CREDIT_W  change amount, valid with change_valid
status_valid  out  1  one-cycle result pulse
vend_status  out  3  1=OK, 2=SOLD_OUT, 3=INSUFFICIENT, 4=INVALID, 5=DISABLED

Behaviour:
- Reset (prst=1 at pclk edge): state IDLE. All outputs 0, including credit, mem_*, and all pulse outputs and their data.
- All outputs are registered. Pulse outputs default to 0 every cycle.
- Credit:
  - Any state: coin_valid adds coin_value to credit, saturating at 2^CREDIT_W-1.
  - Exception, the CHECK-success cycle: credit <= coin_valid ? coin_value : 0.
- IDLE:
  - item_sel_valid && !cfg_mode: latch sel <= item_sel, mem_raddr <= item_sel, go READ.
  - item_sel_valid && cfg_mode: status_valid=1, vend_status=5, stay IDLE.
  - cancel && credit>0 (and no item_sel_valid in the same cycle): change_valid=1, change_value=credit, credit<=0 (a same-cycle coin becomes the new credit).
  - If item_sel_valid and cancel arrive together, selection wins and cancel is dropped.
- READ: one wait cycle for the synchronous memory; mem_rdata is valid in the following cycle. Go CHECK.
- CHECK (evaluate in priority order):
  - sel >= NUM_ITEMS: status 4.
  - stock==0: status 2.
  - credit < price: status 3.
  - Any failure: status_valid=1, credit retained, go IDLE.
  - Success: mem_we=1, mem_waddr=sel, mem_wdata={flags, stock-1, price}; latch chg <= credit - price; update credit as above; go DISPENSE.
- DISPENSE: dispense_valid=1, dispense_item=sel, status_valid=1, vend_status=1. If chg>0, also change_valid=1 and change_value=chg in the same cycle. Go IDLE.
- Latency: item_sel_valid at cycle T gives a failure status at T+3, or dispense/status at T+4. mem_we is asserted at T+3.
- busy=1 in READ, CHECK, DISPENSE. item_sel_valid and cancel are ignored while busy.
- cfg_mode rising mid-transaction does not abort; the transaction completes.
- Credit is never lost across cfg_mode.
- Write port is merged downstream with config writes; configuration has priority. mem_we never asserts while cfg_mode was high at the selection cycle.
- Reset mid-transaction: immediate return to IDLE, no mem_we, credit cleared.

Test Plan:
- Normal vend: slot 5 entry price=150, stock=3; coins 100,100; select 5 -> mem_we at T+3 with wdata[23:16]=2; at T+4 dispense_item=5, change_value=50, status=1, credit=0.
- Sold out: slot 7 stock=0, credit 200; select 7 -> status=2 at T+3, no mem_we, no dispense, credit stays 200.
- Insufficient and cancel: price 300, credit 250; select -> status=3; then cancel -> change_value=250, credit=0.
- Gating and invalid: cfg_mode=1, select 2 -> status=5 next cycle, no memory read. NUM_ITEMS=16, select 20 -> status=4.
- Simultaneous: coin 25 during the CHECK-success cycle -> credit=25 after the vend. Credit at 65530 plus coin 100 -> credit saturates at 65535.
- Reset: assert prst in CHECK -> no mem_we, no dispense; next cycle all outputs 0, busy=0.

Source files
------------

// File: rtl/vend_engine.sv
// vend_engine: credit accumulation, item lookup, stock write-back and
// dispense/change/status pulses for the vending transaction path.
module vend_engine #(
  parameter  int MAX_ITEMS = 1024,
  parameter  int NUM_ITEMS = 1024,
  parameter  int CREDIT_W  = 16,
  localparam int AW        = $clog2(MAX_ITEMS)
) (
  input  logic                pclk,
  input  logic                prst,
  input  logic                cfg_mode,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                cancel,
  input  logic                item_sel_valid,
  input  logic [AW-1:0]       item_sel,
  output logic [AW-1:0]       mem_raddr,
  input  logic [31:0]         mem_rdata,
  output logic                mem_we,
  output logic [AW-1:0]       mem_waddr,
  output logic [31:0]         mem_wdata,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                dispense_valid,
  output logic [AW-1:0]       dispense_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_value,
  output logic                status_valid,
  output logic [2:0]          vend_status
);

  localparam logic [2:0] ST_OK      = 3'd1;
  localparam logic [2:0] ST_SOLD    = 3'd2;
  localparam logic [2:0] ST_INSUFF  = 3'd3;
  localparam logic [2:0] ST_INVALID = 3'd4;
  localparam logic [2:0] ST_DISABLE = 3'd5;
  localparam logic [AW:0] NUM_LIM   = (AW+1)'(NUM_ITEMS);

  typedef enum logic [1:0] {IDLE, READ, CHECK, DISPENSE} state_t;

  state_t              state;
  logic [AW-1:0]       sel;
  logic [CREDIT_W-1:0] chg;
  logic [CREDIT_W-1:0] cred_add;   // credit plus any coin this cycle, saturated
  logic [CREDIT_W-1:0] coin_only;  // credit after a clear, keeping a same-cycle coin
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] price;
  logic [7:0]          stock;
  logic [7:0]          flags;

  assign price = CREDIT_W'(mem_rdata[15:0]);
  assign stock = mem_rdata[23:16];
  assign flags = mem_rdata[31:24];

  // Saturating credit update used by every state except the clearing cases
  always_comb begin
    sum       = {1'b0, credit} + {1'b0, coin_value};
    cred_add  = credit;
    coin_only = coin_valid ? coin_value : '0;
    if (coin_valid)
      cred_add = sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
  end

  // Transaction FSM with all outputs registered
  always_ff @(posedge pclk) begin
    if (prst) begin
      state          <= IDLE;
      sel            <= '0;
      chg            <= '0;
      credit         <= '0;
      busy           <= 1'b0;
      mem_raddr      <= '0;
      mem_we         <= 1'b0;
      mem_waddr      <= '0;
      mem_wdata      <= '0;
      dispense_valid <= 1'b0;
      dispense_item  <= '0;
      change_valid   <= 1'b0;
      change_value   <= '0;
      status_valid   <= 1'b0;
      vend_status    <= '0;
    end else begin
      mem_we         <= 1'b0;
      mem_waddr      <= '0;
      mem_wdata      <= '0;
      dispense_valid <= 1'b0;
      dispense_item  <= '0;
      change_valid   <= 1'b0;
      change_value   <= '0;
      status_valid   <= 1'b0;
      vend_status    <= '0;
      credit         <= cred_add;
      case (state)
        IDLE: begin
          if (item_sel_valid) begin
            if (cfg_mode) begin
              status_valid <= 1'b1;
              vend_status  <= ST_DISABLE;
            end else begin
              sel       <= item_sel;
              mem_raddr <= item_sel;
              state     <= READ;
              busy      <= 1'b1;
            end
          end else if (cancel && credit != '0) begin
            change_valid <= 1'b1;
            change_value <= credit;
            credit       <= coin_only;
          end
        end
        READ: state <= CHECK;
        CHECK: begin
          if ({1'b0, sel} >= NUM_LIM || stock == 8'd0 || credit < price) begin
            status_valid <= 1'b1;
            vend_status  <= ({1'b0, sel} >= NUM_LIM) ? ST_INVALID :
                            (stock == 8'd0)          ? ST_SOLD : ST_INSUFF;
            state        <= IDLE;
            busy         <= 1'b0;
          end else begin
            mem_we    <= 1'b1;
            mem_waddr <= sel;
            mem_wdata <= {flags, stock - 8'd1, mem_rdata[15:0]};
            chg       <= credit - price;
            credit    <= coin_only;
            state     <= DISPENSE;
          end
        end
        DISPENSE: begin
          dispense_valid <= 1'b1;
          dispense_item  <= sel;
          status_valid   <= 1'b1;
          vend_status    <= ST_OK;
          if (chg != '0) begin
            change_valid <= 1'b1;
            change_value <= chg;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_engine.sv
// tb_vend_engine: directed vectors against a small synchronous item memory.
module tb_vend_engine;
  localparam int MAX_ITEMS = 32;
  localparam int NUM_ITEMS = 16;
  localparam int CREDIT_W  = 16;
  localparam int AW        = $clog2(MAX_ITEMS);

  logic                pclk = 1'b0;
  logic                prst;
  logic                cfg_mode, coin_valid, cancel, item_sel_valid;
  logic [CREDIT_W-1:0] coin_value;
  logic [AW-1:0]       item_sel;
  logic [AW-1:0]       mem_raddr, mem_waddr, dispense_item;
  logic [31:0]         mem_rdata, mem_wdata;
  logic                mem_we, busy, dispense_valid, change_valid, status_valid;
  logic [CREDIT_W-1:0] credit, change_value;
  logic [2:0]          vend_status;

  logic [31:0] mem [MAX_ITEMS];
  int checks = 0;
  int failures = 0;

  vend_engine #(.MAX_ITEMS(MAX_ITEMS), .NUM_ITEMS(NUM_ITEMS), .CREDIT_W(CREDIT_W)) dut (
    .pclk(pclk), .prst(prst), .cfg_mode(cfg_mode), .coin_valid(coin_valid),
    .coin_value(coin_value), .cancel(cancel), .item_sel_valid(item_sel_valid),
    .item_sel(item_sel), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .credit(credit), .busy(busy), .dispense_valid(dispense_valid),
    .dispense_item(dispense_item), .change_valid(change_valid),
    .change_value(change_value), .status_valid(status_valid),
    .vend_status(vend_status)
  );

  always #5 pclk = ~pclk;

  // synchronous item memory model
  always @(posedge pclk) begin
    mem_rdata <= mem[mem_raddr];
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1; coin_value = CREDIT_W'(v);
    tick();
    coin_valid = 1'b0; coin_value = '0;
  endtask

  // issue a selection; returns at cycle T+1
  task automatic select(input int s);
    item_sel_valid = 1'b1; item_sel = AW'(s);
    tick();
    item_sel_valid = 1'b0; item_sel = '0;
  endtask

  initial begin
    for (int i = 0; i < MAX_ITEMS; i++) mem[i] = 32'h0;
    mem[5] = {8'hA5, 8'd3, 16'd150};
    mem[7] = {8'h00, 8'd0, 16'd100};
    mem[3] = {8'h00, 8'd5, 16'd300};
    mem[4] = {8'h11, 8'd1, 16'd100};
    mem[6] = {8'h00, 8'd4, 16'd10};
    prst = 1'b1; cfg_mode = 1'b0; coin_valid = 1'b0; coin_value = '0;
    cancel = 1'b0; item_sel_valid = 1'b0; item_sel = '0;
    tick(); tick();
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", {dispense_valid, change_valid, status_valid, mem_we}, 0);
    prst = 1'b0;

    // normal vend
    coin(100); coin(100);
    chk("credit200", 32'(credit), 200);
    select(5);
    chk("busy_read", 32'(busy), 1);
    tick();
    tick();
    chk("vend_we", 32'(mem_we), 1);
    chk("vend_waddr", 32'(mem_waddr), 5);
    chk("vend_wdata", mem_wdata, {8'hA5, 8'd2, 16'd150});
    chk("vend_nodisp_t3", 32'(dispense_valid), 0);
    tick();
    chk("vend_disp", {31'(dispense_item), dispense_valid}, {31'd5, 1'b1});
    chk("vend_change", {31'(change_value), change_valid}, {31'd50, 1'b1});
    chk("vend_status", {29'(vend_status), status_valid}, {29'd1, 1'b1});
    chk("vend_credit", 32'(credit), 0);
    chk("vend_busy", 32'(busy), 0);
    chk("vend_mem", mem[5], {8'hA5, 8'd2, 16'd150});

    // sold out
    coin(100); coin(100);
    select(7); tick(); tick();
    chk("sold_status", {29'(vend_status), status_valid}, {29'd2, 1'b1});
    chk("sold_we", 32'(mem_we), 0);
    chk("sold_credit", 32'(credit), 200);
    tick();
    chk("sold_nodisp", 32'(dispense_valid), 0);
    chk("sold_idle", 32'(busy), 0);

    // insufficient then cancel
    coin(50);
    select(3); tick(); tick();
    chk("insuf_status", {29'(vend_status), status_valid}, {29'd3, 1'b1});
    chk("insuf_credit", 32'(credit), 250);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("cancel_change", {31'(change_value), change_valid}, {31'd250, 1'b1});
    chk("cancel_credit", 32'(credit), 0);

    // gating and invalid slot
    cfg_mode = 1'b1;
    select(2);
    chk("gate_status", {29'(vend_status), status_valid}, {29'd5, 1'b1});
    chk("gate_busy", 32'(busy), 0);
    chk("gate_noread", 32'(mem_raddr), 3);
    cfg_mode = 1'b0;
    select(20); tick(); tick();
    chk("invalid_status", {29'(vend_status), status_valid}, {29'd4, 1'b1});
    chk("invalid_we", 32'(mem_we), 0);

    // coin arriving in the CHECK-success cycle
    coin(100);
    select(4); tick();
    coin(25);
    chk("simul_we", 32'(mem_we), 1);
    chk("simul_credit_t3", 32'(credit), 25);
    tick();
    chk("simul_disp", 32'(dispense_valid), 1);
    chk("simul_nochange", 32'(change_valid), 0);
    chk("simul_credit", 32'(credit), 25);

    // saturation
    coin(65505);
    chk("sat_pre", 32'(credit), 65530);
    coin(100);
    chk("sat", 32'(credit), 65535);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("sat_cancel", 32'(change_value), 65535);

    // reset in CHECK
    coin(10);
    select(6); tick();
    prst = 1'b1; tick(); prst = 1'b0;
    chk("rstmid_we", 32'(mem_we), 0);
    chk("rstmid_outs", {dispense_valid, change_valid, status_valid, busy}, 0);
    chk("rstmid_credit", 32'(credit), 0);
    chk("rstmid_raddr", 32'(mem_raddr), 0);
    tick();
    chk("rstmid_nodisp", 32'(dispense_valid), 0);
    chk("rstmid_mem", mem[6], {8'h00, 8'd4, 16'd10});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
